// File: rtl/odd_period_monitor.sv
// odd_period_monitor
// Measures the high and low run lengths of a toggling input, one rising edge
// to the next, and reports each complete period with a one-cycle valid pulse.
// A run that would overflow its counter is reported on err_sat and the
// partial period is discarded.
// Optional feature macro: ODD_PERIOD_CHECK_EN builds the even-period flag
// err_odd; when the macro is undefined err_odd is tied low.

module odd_period_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  output logic             valid,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W:0]   period,
  output logic             err_sat,
  output logic             err_odd,
  output logic [15:0]      per_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             din_q;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] lo_cnt;
  logic [CNT_W-1:0] hi_next;
  logic [CNT_W-1:0] lo_next;
  logic             rise;
  logic             fall;
  logic             capture;
  logic             sat;
  logic [CNT_W:0]   sum;

  assign rise = din & ~din_q;
  assign fall = ~din & din_q;
  assign sum  = {1'b0, hi_cnt} + {1'b0, lo_cnt};

  // Edge-detect register: samples din every cycle, regardless of en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  // Next-state and run-length counter logic; en low abandons any partial period.
  always_comb begin
    state_next = state;
    hi_next    = hi_cnt;
    lo_next    = lo_cnt;
    capture    = 1'b0;
    sat        = 1'b0;
    if (!en) begin
      state_next = SYNC;
      hi_next    = '0;
      lo_next    = '0;
    end else begin
      case (state)
        SYNC: begin
          hi_next = '0;
          lo_next = '0;
          if (rise) begin
            state_next = HIGH;
            hi_next    = CNT_ONE;
          end
        end
        HIGH: begin
          if (fall) begin
            state_next = LOW;
            lo_next    = CNT_ONE;
          end else if (hi_cnt == CNT_MAX) begin
            sat        = 1'b1;
            state_next = SYNC;
            hi_next    = '0;
            lo_next    = '0;
          end else begin
            hi_next = hi_cnt + CNT_ONE;
          end
        end
        LOW: begin
          if (rise) begin
            capture    = 1'b1;
            state_next = HIGH;
            hi_next    = CNT_ONE;
            lo_next    = '0;
          end else if (lo_cnt == CNT_MAX) begin
            sat        = 1'b1;
            state_next = SYNC;
            hi_next    = '0;
            lo_next    = '0;
          end else begin
            lo_next = lo_cnt + CNT_ONE;
          end
        end
        default: begin
          state_next = SYNC;
          hi_next    = '0;
          lo_next    = '0;
        end
      endcase
    end
  end

  // State and run-length counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= SYNC;
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else begin
      state  <= state_next;
      hi_cnt <= hi_next;
      lo_cnt <= lo_next;
    end
  end

  // Result registers: captured on a closing rise and held until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= 1'b0;
      err_sat  <= 1'b0;
      high_len <= '0;
      low_len  <= '0;
      period   <= '0;
      per_cnt  <= '0;
    end else begin
      valid   <= capture;
      err_sat <= sat;
      if (capture) begin
        high_len <= hi_cnt;
        low_len  <= lo_cnt;
        period   <= sum;
        if (per_cnt != 16'hFFFF) begin
          per_cnt <= per_cnt + 16'd1;
        end
      end
    end
  end

`ifdef ODD_PERIOD_CHECK_EN
  // Even-period flag, registered alongside valid so both pulse together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_odd <= 1'b0;
    end else begin
      err_odd <= capture & ~sum[0];
    end
  end
`else
  assign err_odd = 1'b0;
`endif

endmodule

// File: tb/tb_odd_period_monitor.sv
// tb_odd_period_monitor
// Scoreboard bench: a run-length reference model pushes expected period and
// overflow events at each sampling edge; a monitor pops them whenever the
// DUT pulses valid or err_sat and checks the held outputs in between.

module tb_odd_period_monitor;

  localparam int CNT_W   = 8;
  localparam int RUN_MAX = (1 << CNT_W) - 1;

  typedef struct {
    bit          is_sat;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [8:0]  per;
    logic        odd;
    logic [15:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             din;
  logic             en;
  logic             valid;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W:0]   period;
  logic             err_sat;
  logic             err_odd;
  logic [15:0]      per_cnt;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  odd_period_monitor #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .en       (en),
    .valid    (valid),
    .high_len (high_len),
    .low_len  (low_len),
    .period   (period),
    .err_sat  (err_sat),
    .err_odd  (err_odd),
    .per_cnt  (per_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts high and low samples since the last accepted rise.
  initial begin : model
    int   ones;
    int   zeros;
    bit   armed;
    bit   prev;
    bit   r;
    int   m_cnt;
    exp_t e;
    ones = 0; zeros = 0; armed = 0; prev = 0; m_cnt = 0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        armed = 0; prev = 0; ones = 0; zeros = 0; m_cnt = 0;
        q.delete();
      end else begin
        r = din & ~prev;
        if (!en) begin
          armed = 0; ones = 0; zeros = 0;
        end else if (!armed) begin
          if (r) begin
            armed = 1; ones = 1; zeros = 0;
          end
        end else if (r) begin
          if (m_cnt < 65535) m_cnt++;
          e.is_sat = 0;
          e.hi     = 8'(ones);
          e.lo     = 8'(zeros);
          e.per    = 9'(ones + zeros);
`ifdef ODD_PERIOD_CHECK_EN
          e.odd    = ((ones + zeros) % 2 == 0);
`else
          e.odd    = 1'b0;
`endif
          e.cnt    = 16'(m_cnt);
          q.push_back(e);
          ones = 1; zeros = 0;
        end else begin
          if (din) ones++;
          else     zeros++;
          if (ones > RUN_MAX || zeros > RUN_MAX) begin
            e.is_sat = 1; e.hi = '0; e.lo = '0; e.per = '0; e.odd = 0; e.cnt = '0;
            q.push_back(e);
            armed = 0; ones = 0; zeros = 0;
          end
        end
        prev = din;
      end
    end
  end

  // Monitor: pops one expectation per DUT event, otherwise checks outputs hold.
  initial begin : monitor
    exp_t        e;
    logic [7:0]  last_hi;
    logic [7:0]  last_lo;
    logic [8:0]  last_per;
    logic [15:0] last_cnt;
    last_hi = '0; last_lo = '0; last_per = '0; last_cnt = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_hi = '0; last_lo = '0; last_per = '0; last_cnt = '0;
      end else if (valid || err_sat) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_event: got valid=%0b err_sat=%0b, expected none (t=%0t)", valid, err_sat, $time);
        end else begin
          e = q.pop_front();
          if (e.is_sat) begin
            check_output("sat_pulse", {31'd0, err_sat}, 32'd1);
            check_output("sat_no_valid", {31'd0, valid}, 32'd0);
            check_output("sat_no_odd", {31'd0, err_odd}, 32'd0);
          end else begin
            check_output("valid_pulse", {31'd0, valid}, 32'd1);
            check_output("valid_no_sat", {31'd0, err_sat}, 32'd0);
            check_output("high_len", 32'(high_len), 32'(e.hi));
            check_output("low_len", 32'(low_len), 32'(e.lo));
            check_output("period", 32'(period), 32'(e.per));
            check_output("err_odd", {31'd0, err_odd}, {31'd0, e.odd});
            check_output("per_cnt", 32'(per_cnt), 32'(e.cnt));
            last_hi = e.hi; last_lo = e.lo; last_per = e.per; last_cnt = e.cnt;
          end
        end
      end else begin
        check_output("missing_event", 32'(q.size()), 32'd0);
        check_output("hold_high_len", 32'(high_len), 32'(last_hi));
        check_output("hold_low_len", 32'(low_len), 32'(last_lo));
        check_output("hold_period", 32'(period), 32'(last_per));
        check_output("hold_per_cnt", 32'(per_cnt), 32'(last_cnt));
        check_output("idle_err_odd", {31'd0, err_odd}, 32'd0);
      end
    end
  end

  task automatic apply_stimulus(input bit v, input int n, input bit e);
    repeat (n) begin
      @(negedge clk);
      #1;
      din = v;
      en  = e;
    end
  endtask

  task automatic apply_pattern(input int hi, input int lo, input int reps);
    repeat (reps) begin
      apply_stimulus(1'b1, hi, 1'b1);
      apply_stimulus(1'b0, lo, 1'b1);
    end
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, "_valid"}, {31'd0, valid}, 32'd0);
    check_output({name, "_err_sat"}, {31'd0, err_sat}, 32'd0);
    check_output({name, "_err_odd"}, {31'd0, err_odd}, 32'd0);
    check_output({name, "_high_len"}, 32'(high_len), 32'd0);
    check_output({name, "_low_len"}, 32'(low_len), 32'd0);
    check_output({name, "_period"}, 32'(period), 32'd0);
    check_output({name, "_per_cnt"}, 32'(per_cnt), 32'd0);
  endtask

  // Directed scenarios followed by randomized run lengths with random en drops.
  initial begin : stimulus
    int hi;
    int lo;
    rst = 1'b0;
    din = 1'b0;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    // 3 high / 2 low
    apply_stimulus(1'b0, 3, 1'b1);
    apply_pattern(3, 2, 6);

    // 2 high / 2 low, even period
    apply_pattern(2, 2, 5);

    // high run overflow, then normal periods
    apply_stimulus(1'b0, 2, 1'b1);
    apply_stimulus(1'b1, 300, 1'b1);
    apply_stimulus(1'b0, 3, 1'b1);
    apply_pattern(4, 3, 3);

    // low run overflow, then normal periods
    apply_stimulus(1'b1, 2, 1'b1);
    apply_stimulus(1'b0, 270, 1'b1);
    apply_pattern(3, 3, 3);

    // asynchronous reset in the middle of a low run
    apply_stimulus(1'b1, 3, 1'b1);
    apply_stimulus(1'b0, 2, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    apply_stimulus(1'b0, 2, 1'b1);
    rst = 1'b1;
    apply_stimulus(1'b0, 2, 1'b1);
    apply_pattern(3, 2, 3);

    // en dropped for 3 cycles inside a high run of a 5/4 pattern
    apply_stimulus(1'b0, 3, 1'b1);
    apply_pattern(5, 4, 2);
    apply_stimulus(1'b1, 1, 1'b1);
    apply_stimulus(1'b1, 3, 1'b0);
    apply_stimulus(1'b1, 1, 1'b1);
    apply_stimulus(1'b0, 4, 1'b1);
    apply_pattern(5, 4, 2);
    apply_stimulus(1'b1, 1, 1'b1);

    // randomized run lengths with occasional en drops
    for (int k = 0; k < 80; k++) begin
      hi = $urandom_range(1, 10);
      lo = $urandom_range(1, 10);
      for (int c = 0; c < hi; c++) apply_stimulus(1'b1, 1, ($urandom_range(0, 24) != 0));
      for (int c = 0; c < lo; c++) apply_stimulus(1'b0, 1, ($urandom_range(0, 24) != 0));
    end
    apply_stimulus(1'b1, 2, 1'b1);
    apply_stimulus(1'b0, 4, 1'b1);

    check_output("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/odd_period_monitor.md
ODD_PERIOD_MONITOR -- requirements
Module: odd_period_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of high/low run-length counters.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port din  input  1  toggling signal from the upstream odd-change generator, clk domain.
REQ-005 SHALL have port en  input  1  measurement enable; low forces SYNC.
REQ-006 SHALL have port valid  output  1  one-cycle pulse when a full period has been measured.
REQ-007 SHALL have port high_len  output  CNT_W  cycles din was high in the last period.
REQ-008 SHALL have port low_len  output  CNT_W  cycles din was low in the last period.
REQ-009 SHALL have port period  output  CNT_W+1  high_len+low_len, no truncation.
REQ-010 SHALL have port err_sat  output  1  one-cycle pulse on run-length overflow.
REQ-011 SHALL have port err_odd  output  1  one-cycle pulse, coincident with valid, when period is even.
REQ-012 SHALL have port per_cnt  output  16  count of valid pulses, saturating at 0xFFFF.

Function
REQ-013 SHALL register din into din_q every cycle; rise = din & ~din_q, fall = ~din & din_q.
REQ-014 SHALL implement states SYNC, HIGH, LOW; reset and en=0 enter SYNC.
REQ-015 SYNC: counters held at 0; on rise -> HIGH with hi_cnt=1.
REQ-016 HIGH: hi_cnt+1 per cycle while din high; on fall -> LOW with lo_cnt=1.
REQ-017 LOW: lo_cnt+1 per cycle while din low; on rise -> register high_len=hi_cnt, low_len=lo_cnt, period=sum, assert valid for one cycle, enter HIGH with hi_cnt=1.
REQ-018 valid SHALL assert in the cycle after the clock edge at which the closing rise is sampled (1-cycle latency); outputs hold until the next valid.
REQ-019 If hi_cnt or lo_cnt is 2^CNT_W-1 and the run continues, SHALL pulse err_sat for one cycle, suppress valid, clear counters, enter SYNC.
REQ-020 en deasserting mid-period SHALL discard the partial period (no valid, no err) and enter SYNC next edge; high_len/low_len/period keep last values.
REQ-021 en=0 SHALL not affect din_q sampling, so a rise on the cycle en returns is detected.
REQ-022 per_cnt SHALL increment on each valid, hold at 0xFFFF.

Reset
REQ-023 rst low SHALL immediately clear state to SYNC, din_q, hi_cnt, lo_cnt, high_len, low_len, period, per_cnt to 0 and valid, err_sat, err_odd to 0.
REQ-024 Reset release SHALL require a fresh rise before any measurement; the first valid is the first complete rise-to-rise period.

Configuration
REQ-025 Macro ODD_PERIOD_CHECK_EN: defined -> err_odd = valid & ~period[0] registered with valid; undefined -> err_odd tied 0 and no parity logic built.

Verification
REQ-026 din 3 high/2 low repeating, en=1 -> valid every 5 cycles, high_len=3, low_len=2, period=5, err_odd=0, per_cnt increments.
REQ-027 din 2 high/2 low -> period=4, err_odd=1 with each valid if ODD_PERIOD_CHECK_EN defined, 0 if not.
REQ-028 CNT_W=8, din held high 300 cycles after a rise -> single err_sat pulse when hi_cnt=255, no valid, state SYNC; next full period measured normally.
REQ-029 rst low in the middle of a LOW run -> all outputs 0 asynchronously; after release first valid only after rise, fall, rise.
REQ-030 en dropped for 3 cycles mid-HIGH of a 5/4 pattern -> no valid for the broken period, next valid period=9, high_len=5, low_len=4.
